wall_placer: RTL and testbench

// Generates the wall layout consumed by the wall renderer. On Start, places 1..4 axis-aligned

---
 rtl/wall_placer.sv | 203 ++++++++++++++++++++
 tb/tb_wall_placer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_placer.sv
// wall_placer: on Start, places 1..4 non-overlapping walls at positions drawn from a free-running
// LFSR. After MAX_TRIES rejected candidates for one wall, that wall takes a fixed fallback slot.
module wall_placer #(
    parameter logic [9:0]  X_MAX     = 10'd639,
    parameter logic [9:0]  Y_MAX     = 10'd479,
    parameter logic [9:0]  WALL_W    = 10'd64,
    parameter logic [9:0]  WALL_H    = 10'd64,
    parameter logic [9:0]  MIN_SEP   = 10'd16,
    parameter logic [6:0]  MAX_TRIES = 7'd64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic [2:0] Num_walls,
    output logic       Busy,
    output logic       Done,
    output logic       Valid,
    output logic [3:0] Wall_en,
    output logic [9:0] X1,
    output logic [9:0] X2,
    output logic [9:0] X3,
    output logic [9:0] X4,
    output logic [9:0] Y1,
    output logic [9:0] Y2,
    output logic [9:0] Y3,
    output logic [9:0] Y4
);

    typedef enum logic [2:0] {StIdle, StGen, StCheck, StCommit, StDone} state_e;

    localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [9:0]  XLim    = X_MAX - WALL_W;
    localparam logic [9:0]  YLim    = Y_MAX - WALL_H;
    localparam logic [10:0] XSep    = {1'b0, WALL_W} + {1'b0, MIN_SEP};
    localparam logic [10:0] YSep    = {1'b0, WALL_H} + {1'b0, MIN_SEP};

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  j_q, j_d;
    logic [6:0]  tries_q, tries_d;
    logic [9:0]  xc_q, xc_d;
    logic [9:0]  yc_q, yc_d;
    logic [9:0]  xs_q [4];
    logic [9:0]  xs_d [4];
    logic [9:0]  ys_q [4];
    logic [9:0]  ys_d [4];
    logic [3:0]  en_q, en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;

    logic [9:0]  x_cand, y_cand, xj, yj, fb_x, fb_y;
    logic [10:0] dx, dy;
    logic [6:0]  tries_inc;
    logic        overlap, reject;

    always_comb begin
        x_cand    = lfsr_q[9:0];
        y_cand    = {lfsr_q[15:10], lfsr_q[3:0]};
        xj        = xs_q[j_q];
        yj        = ys_q[j_q];
        dx        = (xc_q >= xj) ? {1'b0, xc_q - xj} : {1'b0, xj - xc_q};
        dy        = (yc_q >= yj) ? {1'b0, yc_q - yj} : {1'b0, yj - yc_q};
        overlap   = (dx < XSep) && (dy < YSep);
        tries_inc = tries_q + 7'd1;
        unique case (idx_q[1:0])
            2'd0: begin fb_x = 10'd16;  fb_y = 10'd16;  end
            2'd1: begin fb_x = 10'd400; fb_y = 10'd200; end
            2'd2: begin fb_x = 10'd160; fb_y = 10'd320; end
            2'd3: begin fb_x = 10'd560; fb_y = 10'd400; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        n_d     = n_q;
        idx_d   = idx_q;
        j_d     = j_q;
        tries_d = tries_q;
        xc_d    = xc_q;
        yc_d    = yc_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        en_d    = en_q;
        valid_d = valid_q;
        reject  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    n_d     = (Num_walls == 3'd0) ? 3'd1 :
                              ((Num_walls > 3'd4) ? 3'd4 : Num_walls);
                    valid_d = 1'b0;
                    en_d    = 4'd0;
                    xs_d    = '{default: '0};
                    ys_d    = '{default: '0};
                    idx_d   = 3'd0;
                    tries_d = 7'd0;
                    state_d = StGen;
                end
            end
            StGen: begin
                xc_d = x_cand;
                yc_d = y_cand;
                if (x_cand > XLim || y_cand > YLim) begin
                    reject = 1'b1;
                end else if (idx_q == 3'd0) begin
                    state_d = StCommit;
                end else begin
                    j_d     = 2'd0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (overlap) begin
                    reject = 1'b1;
                end else if ({1'b0, j_q} == idx_q - 3'd1) begin
                    state_d = StCommit;
                end else begin
                    j_d = j_q + 2'd1;
                end
            end
            StCommit: begin
                xs_d[idx_q[1:0]] = xc_q;
                ys_d[idx_q[1:0]] = yc_q;
                en_d[idx_q[1:0]] = 1'b1;
                idx_d            = idx_q + 3'd1;
                tries_d          = 7'd0;
                state_d          = (idx_q + 3'd1 == n_q) ? StDone : StGen;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Fallback slots bypass the overlap check and go straight to commit.
        if (reject) begin
            tries_d = tries_inc;
            if (tries_inc == MAX_TRIES) begin
                xc_d    = fb_x;
                yc_d    = fb_y;
                state_d = StCommit;
            end else begin
                state_d = StGen;
            end
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
        if (state_d == StDone) valid_d = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            lfsr_q  <= SeedEff;
            n_q     <= 3'd0;
            idx_q   <= 3'd0;
            j_q     <= 2'd0;
            tries_q <= 7'd0;
            xc_q    <= 10'd0;
            yc_q    <= 10'd0;
            xs_q    <= '{default: '0};
            ys_q    <= '{default: '0};
            en_q    <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            tries_q <= tries_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Valid   = valid_q;
    assign Wall_en = en_q;
    assign X1      = xs_q[0];
    assign X2      = xs_q[1];
    assign X3      = xs_q[2];
    assign X4      = xs_q[3];
    assign Y1      = ys_q[0];
    assign Y2      = ys_q[1];
    assign Y3      = ys_q[2];
    assign Y4      = ys_q[3];

endmodule

// File: tb/tb_wall_placer.sv
// Bench for wall_placer: default instance for random layouts, plus a wide-wall instance whose
// walls 2..4 can never be placed legally and must land on the fallback slots.
`timescale 1ns/1ps
module tb_wall_placer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [2:0] nw_a = 3'd0, nw_b = 3'd0;

    logic       busy_a, done_a, valid_a, busy_b, done_b, valid_b;
    logic [3:0] en_a, en_b;
    logic [9:0] x1_a, x2_a, x3_a, x4_a, y1_a, y2_a, y3_a, y4_a;
    logic [9:0] x1_b, x2_b, x3_b, x4_b, y1_b, y2_b, y3_b, y4_b;

    wall_placer dut_a (
        .Clk(clk), .Reset_n(rst_n), .Start(start_a), .Num_walls(nw_a),
        .Busy(busy_a), .Done(done_a), .Valid(valid_a), .Wall_en(en_a),
        .X1(x1_a), .X2(x2_a), .X3(x3_a), .X4(x4_a),
        .Y1(y1_a), .Y2(y2_a), .Y3(y3_a), .Y4(y4_a)
    );

    // Separation of 700/464 exceeds any in-bounds distance, so every check overlaps.
    wall_placer #(.WALL_W(10'd300), .MIN_SEP(10'd400)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .Start(start_b), .Num_walls(nw_b),
        .Busy(busy_b), .Done(done_b), .Valid(valid_b), .Wall_en(en_b),
        .X1(x1_b), .X2(x2_b), .X3(x3_b), .X4(x4_b),
        .Y1(y1_b), .Y2(y2_b), .Y3(y3_b), .Y4(y4_b)
    );

    typedef struct packed {
        logic [3:0] en;
        logic       pred;
        logic [9:0] x1;
        logic [9:0] y1;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [9:0] ax [4];
    logic [9:0] ay [4];
    always_comb begin
        ax[0] = x1_a; ax[1] = x2_a; ax[2] = x3_a; ax[3] = x4_a;
        ay[0] = y1_a; ay[1] = y2_a; ay[2] = y3_a; ay[3] = y4_a;
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR: seed on reset, one shift per clock in every state.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    // First wall of a default-parameter layout: consecutive LFSR states, first in-bounds wins.
    function automatic logic [19:0] predict_first(input logic [15:0] s);
        logic [15:0] v;
        logic [9:0]  xc, yc;
        v = s;
        for (int k = 0; k < 64; k++) begin
            xc = v[9:0];
            yc = {v[15:10], v[3:0]};
            if (xc <= 10'd575 && yc <= 10'd415) return {xc, yc};
            v = lfsr_next(v);
        end
        return {10'd16, 10'd16};
    endfunction

    task automatic start_layout(input bit use_b, input logic [2:0] num);
        exp_t e;
        int   n;
        n = (num == 3'd0) ? 1 : ((num > 3'd4) ? 4 : int'(num));
        if (use_b) begin nw_b = num; start_b = 1'b1; end
        else       begin nw_a = num; start_a = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        e.en   = 4'((1 << n) - 1);
        e.pred = !use_b && (n == 1);
        {e.x1, e.y1} = predict_first(m_lfsr);
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input bit use_b, input int budget, output bit ok);
        int cyc;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            if (use_b ? done_b : done_a) ok = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, done_a, valid_a, en_a} !== 7'd0) begin
            errors++; $display("FAIL reset_ctrl_a: got %b want 0", {busy_a, done_a, valid_a, en_a});
        end
        checks++;
        if ({x1_a, x2_a, x3_a, x4_a, y1_a, y2_a, y3_a, y4_a} !== 80'd0) begin
            errors++; $display("FAIL reset_coords_a: got %h want 0",
                               {x1_a, x2_a, x3_a, x4_a, y1_a, y2_a, y3_a, y4_a});
        end
        checks++;
        if ({busy_b, done_b, valid_b, en_b, x1_b, y1_b} !== 27'd0) begin
            errors++; $display("FAIL reset_b: got %h want 0",
                               {busy_b, done_b, valid_b, en_b, x1_b, y1_b});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        exp_t e;
        bit   ok;
        start_layout(1'b0, 3'd1);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy_a); end
        wait_done(1'b0, 131, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got no Done want Done in 131"); end
        checks++;
        if (en_a !== e.en) begin errors++; $display("FAIL single_en: got %b want %b", en_a, e.en); end
        checks++;
        if ({x1_a, y1_a} !== {e.x1, e.y1}) begin
            errors++; $display("FAIL single_xy: got (%0d,%0d) want (%0d,%0d)", x1_a, y1_a, e.x1, e.y1);
        end
        checks++;
        if (x1_a > 10'd575 || y1_a > 10'd415) begin
            errors++; $display("FAIL single_bounds: got (%0d,%0d) want <=(575,415)", x1_a, y1_a);
        end
        checks++;
        if ({x2_a, x3_a, x4_a, y2_a, y3_a, y4_a} !== 60'd0) begin
            errors++; $display("FAIL single_unused: got %h want 0", {x2_a, x3_a, x4_a, y2_a, y3_a, y4_a});
        end
        checks++;
        if ({valid_a, busy_a} !== 2'b11) begin
            errors++; $display("FAIL single_done_flags: got %b want 11", {valid_a, busy_a});
        end
        @(negedge clk);
        checks++;
        if ({done_a, busy_a, valid_a} !== 3'b001) begin
            errors++; $display("FAIL single_after_done: got %b want 001", {done_a, busy_a, valid_a});
        end
        start_layout(1'b0, 3'd1);
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("FAIL valid_clear: got %b want 0", valid_a); end
        wait_done(1'b0, 131, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || {x1_a, y1_a} !== {e.x1, e.y1}) begin
            errors++; $display("FAIL single2_xy: got (%0d,%0d) ok=%0d want (%0d,%0d)",
                               x1_a, y1_a, ok, e.x1, e.y1);
        end
        @(negedge clk);
    endtask

    task automatic test_clamp;
        exp_t e;
        bit   ok;
        start_layout(1'b0, 3'd0);
        wait_done(1'b0, 131, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || en_a !== e.en || {x1_a, y1_a} !== {e.x1, e.y1}) begin
            errors++; $display("FAIL clamp0: got en=%b (%0d,%0d) ok=%0d want en=%b (%0d,%0d)",
                               en_a, x1_a, y1_a, ok, e.en, e.x1, e.y1);
        end
        @(negedge clk);
        start_layout(1'b0, 3'd7);
        wait_done(1'b0, 2000, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || en_a !== e.en) begin
            errors++; $display("FAIL clamp7: got en=%b ok=%0d want en=%b", en_a, ok, e.en);
        end
        @(negedge clk);
    endtask

    task automatic test_many;
        exp_t e;
        bit   ok, inb, sep;
        int   dx, dy, bad_i, bad_j;
        for (int it = 0; it < 100; it++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            start_layout(1'b0, 3'd4);
            wait_done(1'b0, 2000, ok);
            e = sb_q.pop_front();
            checks++;
            if (!ok || en_a !== e.en) begin
                errors++; $display("FAIL many_en[%0d]: got en=%b ok=%0d want %b", it, en_a, ok, e.en);
            end
            inb = 1'b1;
            sep = 1'b1;
            bad_i = 0;
            bad_j = 0;
            for (int i = 0; i < 4; i++) begin
                if (ax[i] > 10'd575 || ay[i] > 10'd415) inb = 1'b0;
                for (int j = i + 1; j < 4; j++) begin
                    dx = (ax[i] > ax[j]) ? int'(ax[i]) - int'(ax[j]) : int'(ax[j]) - int'(ax[i]);
                    dy = (ay[i] > ay[j]) ? int'(ay[i]) - int'(ay[j]) : int'(ay[j]) - int'(ay[i]);
                    if (dx - 64 < 16 && dy - 64 < 16) begin sep = 1'b0; bad_i = i; bad_j = j; end
                end
            end
            checks++;
            if (!inb) begin errors++; $display("FAIL many_bounds[%0d]: got out-of-bounds want all in", it); end
            checks++;
            if (!sep) begin
                errors++; $display("FAIL many_sep[%0d]: got walls %0d,%0d (%0d,%0d)/(%0d,%0d) want gap>=16",
                                   it, bad_i + 1, bad_j + 1, ax[bad_i], ay[bad_i], ax[bad_j], ay[bad_j]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fallback;
        exp_t e;
        bit   ok, w1_ok;
        start_layout(1'b1, 3'd4);
        wait_done(1'b1, 3000, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL fb_timeout: got no Done want Done"); end
        checks++;
        if (en_b !== e.en) begin errors++; $display("FAIL fb_en: got %b want %b", en_b, e.en); end
        checks++;
        if ({x2_b, y2_b, x3_b, y3_b, x4_b, y4_b} !==
            {10'd400, 10'd200, 10'd160, 10'd320, 10'd560, 10'd400}) begin
            errors++; $display("FAIL fb_slots: got (%0d,%0d)(%0d,%0d)(%0d,%0d) want (400,200)(160,320)(560,400)",
                               x2_b, y2_b, x3_b, y3_b, x4_b, y4_b);
        end
        w1_ok = ({x1_b, y1_b} == {10'd16, 10'd16}) || (x1_b <= 10'd339 && y1_b <= 10'd415);
        checks++;
        if (!w1_ok) begin errors++; $display("FAIL fb_wall1: got (%0d,%0d) want in bounds", x1_b, y1_b); end
        @(negedge clk);
        checks++;
        if ({done_b, busy_b, valid_b} !== 3'b001) begin
            errors++; $display("FAIL fb_after_done: got %b want 001", {done_b, busy_b, valid_b});
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc, low, pulses, busy_late;
        start_layout(1'b0, 3'd4);
        cyc = 1;
        low = 0;
        while (!done_a && cyc < 2000) begin
            if (!busy_a) low++;
            start_a = (cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (!done_a || en_a !== e.en) begin
            errors++; $display("FAIL b2b_done: got done=%b en=%b want 1 %b", done_a, en_a, e.en);
        end
        checks++;
        if (low != 0) begin errors++; $display("FAIL b2b_busy: got %0d low cycles want 0", low); end
        pulses = 0;
        busy_late = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done_a) pulses++;
            if (busy_a) busy_late++;
        end
        checks++;
        if (pulses != 0 || busy_late != 0) begin
            errors++; $display("FAIL b2b_ignored: got %0d extra Done, %0d busy want 0, 0", pulses, busy_late);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bit   ok;
        start_layout(1'b0, 3'd4);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        checks++;
        if ({busy_a, done_a, valid_a, en_a, x1_a, y1_a} !== 27'd0) begin
            errors++; $display("FAIL midreset: got %h want 0", {busy_a, done_a, valid_a, en_a, x1_a, y1_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_layout(1'b0, 3'd2);
        wait_done(1'b0, 2000, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || en_a !== e.en || valid_a !== 1'b1) begin
            errors++; $display("FAIL midreset_restart: got en=%b valid=%b ok=%0d want %b 1",
                               en_a, valid_a, ok, e.en);
        end
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_clamp();
        test_fallback();
        test_back_to_back();
        test_reset_mid();
        test_many();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
